// File: rtl/local_ni.sv
// Local network interface: bit-serial busy/data link to a router's local port,
// with a one-flit TX holding register, a one-flit RX holding register and per-direction flit counters.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 4
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

module local_ni #(
    parameter int niid   = -1,
    parameter int FLIT_W = `PAYLOAD_SIZE + `ADDR_SZ
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLIT_W-1:0] in_flit,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              link_tx_data,
    input  logic              link_tx_busy,
    input  logic              link_rx_data,
    output logic              link_rx_busy,
    output logic [FLIT_W-1:0] out_flit,
    output logic              out_valid,
    input  logic              out_ack,
    output logic [19:0]       tx_count,
    output logic [19:0]       rx_count,
    output logic              rx_err
);
    localparam int CW = (FLIT_W > 1) ? $clog2(FLIT_W) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(FLIT_W - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_GAP} tx_state_t;
    typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;

    tx_state_t         tx_state;
    logic [FLIT_W-1:0] tx_buf;
    logic              tx_full;
    logic [CW-1:0]     tx_bit;

    rx_state_t         rx_state;
    logic [FLIT_W-2:0] rx_shift;
    logic [CW-1:0]     rx_bit;
    logic              rx_drop;
    logic              ack_fire;

    assign in_ready = ~tx_full;
    assign ack_fire = out_valid & out_ack;

    // TX bits are picked from the holding register by index, so a reload during GAP cannot corrupt a frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state     <= TX_IDLE;
            tx_buf       <= '0;
            tx_full      <= 1'b0;
            tx_bit       <= '0;
            link_tx_data <= 1'b0;
            tx_count     <= '0;
        end else begin
            if (in_valid && !tx_full) begin
                tx_buf  <= in_flit;
                tx_full <= 1'b1;
            end
            case (tx_state)
                TX_IDLE: begin
                    link_tx_data <= 1'b0;
                    if (tx_full && !link_tx_busy) begin
                        link_tx_data <= 1'b1;
                        tx_state     <= TX_START;
                    end
                end
                TX_START: begin
                    link_tx_data <= tx_buf[0];
                    tx_bit       <= CW'(1);
                    tx_state     <= TX_DATA;
                end
                TX_DATA: begin
                    link_tx_data <= tx_buf[tx_bit];
                    tx_bit       <= tx_bit + CW'(1);
                    if (tx_bit == LAST_BIT) begin
                        tx_full  <= 1'b0;
                        tx_count <= tx_count + 20'd1;
                        tx_state <= TX_GAP;
                    end
                end
                TX_GAP: begin
                    link_tx_data <= 1'b0;
                    tx_state     <= TX_IDLE;
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // An ack is handled before a same-edge start bit, so that frame is accepted rather than flagged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state     <= RX_IDLE;
            rx_shift     <= '0;
            rx_bit       <= '0;
            rx_drop      <= 1'b0;
            out_flit     <= '0;
            out_valid    <= 1'b0;
            link_rx_busy <= 1'b0;
            rx_err       <= 1'b0;
            rx_count     <= '0;
        end else begin
            if (ack_fire) begin
                out_valid    <= 1'b0;
                link_rx_busy <= 1'b0;
                rx_count     <= rx_count + 20'd1;
            end
            case (rx_state)
                RX_IDLE: begin
                    if (link_rx_data) begin
                        link_rx_busy <= 1'b1;
                        rx_bit       <= '0;
                        rx_drop      <= out_valid & ~out_ack;
                        if (out_valid && !out_ack) begin
                            rx_err <= 1'b1;
                        end
                        rx_state <= RX_RECV;
                    end
                end
                RX_RECV: begin
                    rx_shift <= {link_rx_data, rx_shift[FLIT_W-2:1]};
                    rx_bit   <= rx_bit + CW'(1);
                    if (rx_bit == LAST_BIT) begin
                        rx_state <= RX_IDLE;
                        if (!rx_drop) begin
                            out_flit  <= {link_rx_data, rx_shift};
                            out_valid <= 1'b1;
                        end
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_local_ni.sv
// Directed plus randomized bench for local_ni; expectations come from a frame-level
// model of the link (bit lists per flit) and a one-entry RX holding model.
module tb_local_ni;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_flit;
    logic         in_valid;
    logic         in_ready;
    logic         link_tx_data;
    logic         link_tx_busy;
    logic         link_rx_data;
    logic         link_rx_busy;
    logic [W-1:0] out_flit;
    logic         out_valid;
    logic         out_ack;
    logic [19:0]  tx_count;
    logic [19:0]  rx_count;
    logic         rx_err;

    logic         rx_drive;
    logic         loopback;

    int vectors = 0;
    int miscompares = 0;

    logic [19:0]  m_tx_count;
    logic [19:0]  m_rx_count;
    logic         m_valid;
    logic         m_busy;
    logic         m_err;
    logic [W-1:0] m_flit;

    logic [W-1:0] tx_q[$];
    bit           exp_bits[$];

    assign link_rx_data = loopback ? link_tx_data : rx_drive;

    always #5 clk = ~clk;

    local_ni #(.niid(0), .FLIT_W(W)) dut (
        .clk(clk), .reset(reset),
        .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
        .link_tx_data(link_tx_data), .link_tx_busy(link_tx_busy),
        .link_rx_data(link_rx_data), .link_rx_busy(link_rx_busy),
        .out_flit(out_flit), .out_valid(out_valid), .out_ack(out_ack),
        .tx_count(tx_count), .rx_count(rx_count), .rx_err(rx_err)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_tx_data"},  32'(link_tx_data), 32'd0);
        checkOutput({tag, "_rx_busy"},  32'(link_rx_busy), 32'd0);
        checkOutput({tag, "_out_valid"}, 32'(out_valid),   32'd0);
        checkOutput({tag, "_in_ready"}, 32'(in_ready),     32'd1);
        checkOutput({tag, "_rx_err"},   32'(rx_err),       32'd0);
        checkOutput({tag, "_tx_count"}, 32'(tx_count),     32'd0);
        checkOutput({tag, "_rx_count"}, 32'(rx_count),     32'd0);
        checkOutput({tag, "_out_flit"}, 32'(out_flit),     32'd0);
    endtask

    task automatic check_rx_model(input string tag);
        checkOutput({tag, "_out_valid"}, 32'(out_valid),    32'(m_valid));
        checkOutput({tag, "_out_flit"},  32'(out_flit),     32'(m_flit));
        checkOutput({tag, "_rx_busy"},   32'(link_rx_busy), 32'(m_busy));
        checkOutput({tag, "_rx_err"},    32'(rx_err),       32'(m_err));
        checkOutput({tag, "_rx_count"},  32'(rx_count),     32'(m_rx_count));
    endtask

    // Sends every flit in tx_q as soon as in_ready allows and compares the line against
    // the expected stream: idle 0, then per flit {start 1, data LSB first, one gap 0}.
    task automatic applyStimulus();
        int n;
        int nxt;
        n = tx_q.size();
        exp_bits = {};
        exp_bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            exp_bits.push_back(1'b1);
            for (int b = 0; b < W; b++) exp_bits.push_back(tx_q[i][b]);
            exp_bits.push_back(1'b0);
        end
        exp_bits.push_back(1'b0);
        in_flit  = tx_q[0];
        in_valid = 1'b1;
        nxt = 1;
        for (int c = 0; c < exp_bits.size(); c++) begin
            tick();
            checkOutput("tx_line", 32'(link_tx_data), 32'(exp_bits[c]));
            if (n == 1) checkOutput("tx_in_ready", 32'(in_ready), 32'(c >= W + 1));
            if (in_ready && nxt < n) begin
                in_flit  = tx_q[nxt];
                in_valid = 1'b1;
                nxt++;
            end else begin
                in_valid = 1'b0;
            end
        end
        m_tx_count = m_tx_count + 20'(n);
        checkOutput("tx_count", 32'(tx_count), 32'(m_tx_count));
    endtask

    task automatic rx_frame(input logic [W-1:0] f, input bit ack_same);
        bit drop;
        rx_drive = 1'b1;
        out_ack  = ack_same;
        tick();
        out_ack = 1'b0;
        if (ack_same && m_valid) begin
            m_valid = 1'b0;
            m_busy  = 1'b0;
            m_rx_count++;
        end
        drop = m_valid;
        if (drop) m_err = 1'b1;
        m_busy = 1'b1;
        check_rx_model("rx_start");
        for (int b = 0; b < W; b++) begin
            rx_drive = f[b];
            tick();
        end
        rx_drive = 1'b0;
        if (!drop) begin
            m_flit  = f;
            m_valid = 1'b1;
        end
        check_rx_model("rx_end");
    endtask

    task automatic rx_ack();
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        if (m_valid) begin
            m_valid = 1'b0;
            m_busy  = 1'b0;
            m_rx_count++;
        end
        check_rx_model("rx_ack");
    endtask

    task automatic model_reset();
        m_tx_count = '0;
        m_rx_count = '0;
        m_valid    = 1'b0;
        m_busy     = 1'b0;
        m_err      = 1'b0;
        m_flit     = '0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] f;
        int mode;
        reset = 1'b0; in_flit = '0; in_valid = 1'b0; link_tx_busy = 1'b0;
        rx_drive = 1'b0; loopback = 1'b0; out_ack = 1'b0;
        model_reset();
        tick(); tick();
        check_reset_values("reset");
        reset = 1'b1;
        tick();

        tx_q = {8'hA5};
        applyStimulus();

        rx_frame(8'h3C, 1'b0);
        repeat (5) tick();
        check_rx_model("rx_hold");
        rx_frame(8'h77, 1'b0);
        rx_ack();
        rx_ack();
        rx_frame(8'h11, 1'b0);
        rx_ack();

        // Busy from the router stalls TX with the line idle until released.
        f = 8'h96;
        link_tx_busy = 1'b1;
        in_flit = f;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("busy_hold_line", 32'(link_tx_data), 32'd0);
        end
        link_tx_busy = 1'b0;
        for (int c = 1; c <= W + 2; c++) begin
            tick();
            checkOutput("busy_release_line", 32'(link_tx_data),
                        32'((c == 1) ? 1'b1 : (c <= W + 1) ? f[c-2] : 1'b0));
        end
        m_tx_count++;
        checkOutput("busy_tx_count", 32'(tx_count), 32'(m_tx_count));

        tx_q = {8'h01, 8'h02, 8'h03};
        applyStimulus();

        tx_q = {};
        for (int i = 0; i < 4; i++) tx_q.push_back(W'($urandom));
        applyStimulus();

        for (int i = 0; i < 6; i++) begin
            mode = int'($urandom_range(0, 2));
            if (mode == 1) rx_ack();
            rx_frame(W'($urandom), mode == 2);
        end
        rx_ack();

        // Abort a TX and an RX frame mid-flight with the asynchronous reset.
        in_flit = 8'hC3;
        in_valid = 1'b1;
        rx_drive = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            rx_drive = b[0];
            tick();
        end
        #2 reset = 1'b0;
        #1 check_reset_values("async_reset");
        model_reset();
        tick();
        rx_drive = 1'b0;
        reset = 1'b1;
        tick();
        check_reset_values("after_reset");

        loopback = 1'b1;
        tx_q = {8'h5A};
        applyStimulus();
        loopback = 1'b0;
        m_flit  = 8'h5A;
        m_valid = 1'b1;
        m_busy  = 1'b1;
        check_rx_model("loopback");
        rx_ack();

        force dut.tx_count = 20'hFFFFF;
        tick();
        release dut.tx_count;
        m_tx_count = 20'hFFFFF;
        tx_q = {W'($urandom)};
        applyStimulus();

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/local_ni.md
# local_ni

Local network interface at the far end of a router's local port: the processing element's side of the link. Serializes parallel flits from the processing element onto the router's local receive line. Deserializes flits arriving on the router's local transmit line into a one-entry parallel holding register. Both directions use the bit-serial busy/data link protocol defined below, and the block keeps per-direction flit counters.

## Interface
- `niid`, -1, identifier of the attached router, for simulation messages only
- `FLIT_W`, `` `PAYLOAD_SIZE+`ADDR_SZ ``, flit width (destination address in the upper `` `ADDR_SZ `` bits)
- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `in_flit`  in  FLIT_W  flit from the processing element
- `in_valid`  in  1  `in_flit` is valid
- `in_ready`  out  1  TX holding register empty; transfer happens when `in_valid & in_ready` at a clock edge
- `link_tx_data`  out  1  serial line into the router's local receiver
- `link_tx_busy`  in  1  router's local receiver is busy
- `link_rx_data`  in  1  serial line from the router's local transmitter
- `link_rx_busy`  out  1  this block's receiver is busy; router must not start a frame
- `out_flit`  out  FLIT_W  received flit
- `out_valid`  out  1  `out_flit` is valid
- `out_ack`  in  1  processing element consumes `out_flit`
- `tx_count`  out  20  flits sent, wraps modulo 2^20
- `rx_count`  out  20  flits consumed via `out_ack`, wraps modulo 2^20
- `rx_err`  out  1  sticky: a start bit arrived while the RX holding register was full

## Operation
- Link frame: idle line is 0. A frame is one start bit (1), then FLIT_W data bits LSB first, one bit per clock. All serial outputs are registered.
- TX FSM, states IDLE, START, DATA, GAP:
  - IDLE: if the holding register is full and `link_tx_busy` samples 0, go to START. `link_tx_data` is 1 for the following cycle.
  - START: go to DATA, shifting bit 0.
  - DATA: shift FLIT_W bits. On the edge that drives the last bit, free the holding register and increment `tx_count`. Then go to GAP.
  - GAP: drive 0 for one cycle, then go to IDLE. This guarantees the receiver's registered busy is visible before the next frame.
- TX holding register: `in_ready = ~full`. It loads on `in_valid & in_ready`. It may be reloaded while GAP is in progress; the new flit cannot start before IDLE.
- RX FSM, states IDLE, RECV:
  - IDLE: `link_rx_data` sampled 1 sets `link_rx_busy` and clears the bit counter. Go to RECV.
  - RECV: shift in FLIT_W bits. On the edge sampling the last bit, load `out_flit`, set `out_valid`, and return to IDLE.
- `link_rx_busy` stays 1 from the start-bit edge until the edge where `out_valid & out_ack`. On that edge `out_valid` clears, `link_rx_busy` clears and `rx_count` increments.
- Protocol violation: a start bit sampled in RX IDLE while `out_valid=1`:
  - set `rx_err`;
  - ignore the frame (still consume FLIT_W bits in RECV, discarding them);
  - leave `out_flit` unchanged.
- `out_ack` while `out_valid=0` is ignored.

## Timing
- Reset (`reset=0`, asynchronous) forces:
  - FSMs to IDLE;
  - `link_tx_data=0`, `link_rx_busy=0`, `out_valid=0`, `in_ready=1`, `rx_err=0`;
  - `tx_count=0`, `rx_count=0`, `out_flit=0`.
- Reset mid-frame aborts the frame. The line returns to 0 immediately, and the partially sent or received flit is lost.
- TX latency:
  - flit accepted at edge E0;
  - start bit on the line after E1 (if `link_tx_busy=0` at E1);
  - bit k on the line after E(2+k);
  - `in_ready` high after E(1+FLIT_W);
  - earliest next start bit after E(3+FLIT_W).
- `link_tx_busy=1` holds TX in IDLE indefinitely with no timeout. The frame starts on the first edge that samples 0.
- RX latency: start bit sampled at edge R0; `link_rx_busy=1` after R0; `out_valid=1` after R(FLIT_W).
- Same-edge `out_ack` and a new start bit: the ack is processed first. The frame is accepted and `rx_err` is not set.
- Counters use plain binary +1 and roll over from 0xFFFFF to 0x00000.

## Test plan
- FLIT_W=8, `in_flit=0xA5` with `link_tx_busy=0` -> line shows 1,1,0,1,0,0,1,0,1 on consecutive cycles starting after E1, then 0; `tx_count=1`; `in_ready` returns after E9.
- Drive the frame 1 + 0x3C LSB first on `link_rx_data` with `out_ack=0` -> `out_flit=0x3C`, `out_valid=1`, `link_rx_busy` held 1. Pulse `out_ack` -> both clear next edge; `rx_count=1`.
- Hold `link_tx_busy=1` for 20 cycles with a flit loaded -> line stays 0. Release -> start bit after the first edge sampling 0.
- Send a second frame while 0x3C is unacknowledged -> `rx_err=1` and `out_flit` remains 0x3C. Ack the flit, then send 0x11 -> 0x11 received normally.
- Back-to-back `in_valid` with 0x01, 0x02, 0x03 -> frames separated by exactly one idle 0 cycle; `tx_count=3`.
- Assert `reset=0` in the middle of a TX frame and an RX frame -> all outputs at reset values immediately. After release, a new 0x5A round-trips correctly. Preload `tx_count=0xFFFFF` by force and send one flit -> `tx_count=0`.
